// File: rtl/segment_display_arbiter_if.sv
// Source/display bundle for segment_display_arbiter.
// Alert signals exist only when SEG_ARB_ALERT_EN is defined.
interface segment_display_arbiter_if #(
  parameter int unsigned SRC_W = 2
);
  localparam int unsigned NUM_SRC = 2**SRC_W;

  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC*12-1:0] src_data;
  logic [NUM_SRC*3-1:0]  src_dp;
  logic                  freeze;
`ifdef SEG_ARB_ALERT_EN
  logic                  alert_valid;
  logic [11:0]           alert_data;
  logic [2:0]            alert_dp;
`endif
  logic [11:0]           disp_data;
  logic [2:0]            disp_dp;
  logic                  disp_blank;
  logic [SRC_W-1:0]      cur_src;
  logic                  slot_start;

  modport master (
`ifdef SEG_ARB_ALERT_EN
    output alert_valid, alert_data, alert_dp,
`endif
    output src_valid, src_data, src_dp, freeze,
    input  disp_data, disp_dp, disp_blank, cur_src, slot_start
  );

  modport slave (
`ifdef SEG_ARB_ALERT_EN
    input  alert_valid, alert_data, alert_dp,
`endif
    input  src_valid, src_data, src_dp, freeze,
    output disp_data, disp_dp, disp_blank, cur_src, slot_start
  );
endinterface

// File: rtl/segment_display_arbiter.sv
// Round-robin time-sharing of status sources onto a 3-digit 7-segment display.
// Alert preemption (ALERT state, hold counter) is built when SEG_ARB_ALERT_EN is defined.
module segment_display_arbiter #(
  parameter int unsigned SRC_W      = 2,
  parameter logic [23:0] DWELL      = 24'd5_000_000
`ifdef SEG_ARB_ALERT_EN
  ,
  parameter logic [23:0] ALERT_HOLD = 24'd10_000_000
`endif
) (
  input logic                      clk,
  input logic                      rst,
  segment_display_arbiter_if.slave bus
);
  localparam int unsigned NUM_SRC = 2**SRC_W;

`ifdef SEG_ARB_ALERT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_ALERT} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_SHOW} state_t;
`endif

  state_t           r_state, w_nxt_state;
  logic [SRC_W-1:0] r_cur_src, w_nxt_src;
  logic [23:0]      r_cnt, w_nxt_cnt;
  logic [11:0]      r_disp_data, w_nxt_data;
  logic [2:0]       r_disp_dp, w_nxt_dp;
  logic             r_disp_blank, w_nxt_blank;
  logic             r_slot_start, w_nxt_slot;
  logic             w_pick_ok;
  logic [SRC_W-1:0] w_pick_idx;
  logic [11:0]      w_src_data [NUM_SRC];
  logic [2:0]       w_src_dp   [NUM_SRC];
`ifdef SEG_ARB_ALERT_EN
  logic [23:0]      r_hold, w_nxt_hold;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_src_data[g] = bus.src_data[12*g +: 12];
    assign w_src_dp[g]   = bus.src_dp[3*g +: 3];
  end

  // Search order cur+1 .. cur (wrapping); cur itself is the last candidate.
  always_comb begin
    w_pick_ok  = 1'b0;
    w_pick_idx = r_cur_src;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (!w_pick_ok && bus.src_valid[r_cur_src + SRC_W'(k)]) begin
        w_pick_ok  = 1'b1;
        w_pick_idx = r_cur_src + SRC_W'(k);
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_src   = r_cur_src;
    w_nxt_cnt   = r_cnt;
    w_nxt_slot  = 1'b0;
`ifdef SEG_ARB_ALERT_EN
    w_nxt_hold  = r_hold;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_ok) begin
          w_nxt_state = ST_SHOW;
          w_nxt_src   = w_pick_idx;
          w_nxt_cnt   = '0;
          w_nxt_slot  = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!bus.src_valid[r_cur_src]) begin
          w_nxt_cnt = '0;
          if (w_pick_ok) begin
            w_nxt_src  = w_pick_idx;
            w_nxt_slot = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else if (!bus.freeze) begin
          if (r_cnt == DWELL - 24'd1) begin
            w_nxt_src  = w_pick_idx;
            w_nxt_cnt  = '0;
            w_nxt_slot = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + 24'd1;
          end
        end
      end
`ifdef SEG_ARB_ALERT_EN
      ST_ALERT: begin
        if (!bus.alert_valid && (r_hold >= ALERT_HOLD - 24'd1)) begin
          w_nxt_cnt = '0;
          if (bus.src_valid[r_cur_src]) begin
            w_nxt_state = ST_SHOW;
            w_nxt_slot  = 1'b1;
          end else if (w_pick_ok) begin
            w_nxt_state = ST_SHOW;
            w_nxt_src   = w_pick_idx;
            w_nxt_slot  = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else if (r_hold < ALERT_HOLD - 24'd1) begin
          w_nxt_hold = r_hold + 24'd1;
        end
      end
`endif
      default: w_nxt_state = ST_IDLE;
    endcase

`ifdef SEG_ARB_ALERT_EN
    // Alert entry overrides every SHOW/IDLE decision above, including expiry.
    if (bus.alert_valid && (r_state != ST_ALERT)) begin
      w_nxt_state = ST_ALERT;
      w_nxt_src   = r_cur_src;
      w_nxt_cnt   = r_cnt;
      w_nxt_slot  = 1'b0;
      w_nxt_hold  = '0;
    end
`endif

    // Outputs are registered from the next-state view so data tracks sources live.
    w_nxt_data  = '0;
    w_nxt_dp    = '0;
    w_nxt_blank = 1'b1;
    case (w_nxt_state)
      ST_SHOW: begin
        w_nxt_data  = w_src_data[w_nxt_src];
        w_nxt_dp    = w_src_dp[w_nxt_src];
        w_nxt_blank = 1'b0;
      end
`ifdef SEG_ARB_ALERT_EN
      ST_ALERT: begin
        w_nxt_data  = bus.alert_data;
        w_nxt_dp    = bus.alert_dp;
        w_nxt_blank = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur_src    <= '0;
      r_cnt        <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= 1'b1;
      r_slot_start <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cur_src    <= w_nxt_src;
      r_cnt        <= w_nxt_cnt;
      r_disp_data  <= w_nxt_data;
      r_disp_dp    <= w_nxt_dp;
      r_disp_blank <= w_nxt_blank;
      r_slot_start <= w_nxt_slot;
    end
  end

`ifdef SEG_ARB_ALERT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_nxt_hold;
    end
  end
`endif

  assign bus.disp_data  = r_disp_data;
  assign bus.disp_dp    = r_disp_dp;
  assign bus.disp_blank = r_disp_blank;
  assign bus.cur_src    = r_cur_src;
  assign bus.slot_start = r_slot_start;

endmodule

// File: doc/segment_display_arbiter.md
# segment_display_arbiter

Time-shares the 3-digit 7-segment display among up to 2**SRC_W status sources (hash rate, nonce progress, temperature, error code, …). Rotates through valid sources round-robin with a programmable dwell time. An alert source, compiled in optionally, preempts the rotation. Sits directly upstream of `segment_display` and drives its `data`/`dp` inputs from registered outputs.

## Interface
- SRC_W, 2: source index width; NUM_SRC = 2**SRC_W sources.
- DWELL, 24'd5_000_000: cycles per slot; must be ≥ 2.
- ALERT_HOLD, 24'd10_000_000: minimum cycles an alert stays displayed; must be ≥ 1.
- Clock, reset and direction rules:
  - `clk` input, 1 bit: single clock; every register is on its rising edge.
  - `rst` input, 1 bit: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `src_valid` input NUM_SRC: per-source level, 1 = has content to show.
- `src_data` input NUM_SRC*12: source i occupies bits [12i+11:12i], 3 hex digits.
- `src_dp` input NUM_SRC*3: source i occupies bits [3i+2:3i], decimal points, active-high.
- `freeze` input 1: holds the current slot. The dwell counter stops.
- `alert_valid` input 1: alert request, level-sensitive. Present only with SEG_ARB_ALERT_EN.
- `alert_data` input 12: alert digits. Present only with SEG_ARB_ALERT_EN.
- `alert_dp` input 3: alert decimal points. Present only with SEG_ARB_ALERT_EN.
- `disp_data` output 12: to `segment_display.data`.
- `disp_dp` output 3: to `segment_display.dp`.
- `disp_blank` output 1: 1 = no content. Downstream gates display enable with it.
- `cur_src` output SRC_W: index of the source being shown or last shown.
- `slot_start` output 1: one-cycle pulse on the first cycle of each new SHOW slot.

## Operation
- States: IDLE, SHOW, ALERT. Reset enters IDLE.
- Round-robin search: starts at `cur_src`+1, wraps modulo NUM_SRC, ends at `cur_src`. The first source with `src_valid`=1 is chosen.
- IDLE:
  - disp_blank=1, disp_data=0, disp_dp=0.
  - If any `src_valid` is 1: perform the search, load `cur_src`, clear the counter, go to SHOW, pulse `slot_start`.
- SHOW:
  - Each cycle, disp_data/disp_dp register src_data/src_dp of `cur_src` (live tracking). disp_blank=0.
  - Counter increments unless `freeze`=1.
  - Dwell expiry: when counter==DWELL-1 and `freeze`=0, perform the search.
    - If a different valid source is found: switch to it, clear the counter, pulse `slot_start`.
    - If only `cur_src` is valid: stay on it, clear the counter, pulse `slot_start`.
  - Source drop: if `src_valid[cur_src]`=0, the slot ends that cycle regardless of counter or `freeze`.
    - Perform the search. If nothing is valid, go to IDLE.
- ALERT (SEG_ARB_ALERT_EN only):
  - `alert_valid`=1 in IDLE or SHOW moves the block to ALERT on the next edge.
  - While in ALERT: disp_data=alert_data, disp_dp=alert_dp, disp_blank=0. `cur_src` is frozen. The hold counter counts from 0.
  - Exit requires both `alert_valid`=0 and hold counter ≥ ALERT_HOLD-1.
    - If `src_valid[cur_src]`=1 after exit: return to SHOW on `cur_src`, counter=0, pulse `slot_start`.
    - Otherwise: run the search from IDLE rules.
  - Re-assertion of `alert_valid` while in ALERT does not restart the hold counter.
- Priority, highest first: reset > alert entry > source drop > dwell expiry > freeze.
- `freeze` is ignored in IDLE and ALERT.

## Timing
- All outputs are registered.
- Reset values: disp_data=12'h000, disp_dp=3'b000, disp_blank=1, cur_src=0, slot_start=0.
- Latency:
  - `src_valid` asserting in IDLE produces valid output 1 cycle later.
  - Live data change in SHOW appears on disp_data 1 cycle later.
  - `alert_valid` rising appears on outputs 1 cycle later.
- Slot length without freeze or drop is exactly DWELL cycles, measured from one `slot_start` pulse to the next.
- Alert display lasts max(ALERT_HOLD, alert_valid high time) cycles.
- Reset mid-slot or mid-alert returns the block to IDLE immediately. After reset release, the next search starts at index 1 because cur_src=0.

## Configuration
- `SEG_ARB_ALERT_EN` defined:
  - `alert_*` ports exist.
  - ALERT state and hold counter are built.
- `SEG_ARB_ALERT_EN` undefined:
  - `alert_*` ports are absent.
  - No ALERT state exists; the block is pure round-robin with freeze.

## Test plan
- Rotation: SRC_W=2, DWELL=4, valid=4'b1111. `cur_src` sequence is 1,2,3,0,1. `slot_start` fires every 4 cycles. disp_data equals the corresponding 12-bit field.
- Skip and idle:
  - valid=4'b0101: `cur_src` alternates 2,0.
  - Then valid=0: disp_blank=1 and disp_data=0 on the next cycle.
- Drop and freeze:
  - freeze=1 in SHOW for 10 cycles: the slot extends to 14 cycles.
  - Deassert `src_valid[cur_src]` mid-slot with freeze=1: the next source is shown 1 cycle later.
- Alert (macro on), ALERT_HOLD=6: pulse alert_valid=1 for 1 cycle with alert_data=12'hE01.
  - disp_data=12'hE01 for 6 cycles.
  - Then the block returns to the prior `cur_src`, pulses `slot_start`, and gets a full DWELL slot.
- Alert vs expiry: assert alert_valid on the counter==DWELL-1 cycle. ALERT wins and `cur_src` is unchanged.
- Reset mid-operation: assert rst=0 mid-SHOW. All outputs take reset values asynchronously, and the block resumes from IDLE after release.
